regfile_multiport: RTL and testbench

// Parametrised multi-port integer register file for the RV32I cores; next generation of the

---
 rtl/regfile_multiport.sv | 99 +++++++++
 tb/tb_regfile_multiport.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multi-port integer register file with optional same-cycle write-to-read bypass and a
// post-reset clear sequencer that zeroes every register before ready_o rises.
module regfile_multiport #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_READ       = 2,
  parameter int NUM_WRITE      = 2,
  parameter int BYPASS         = 1,
  parameter int ZERO_REG       = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  output logic                               ready_o,
  input  logic [NUM_READ*REG_ADDR_WIDTH-1:0]  read_address_i,
  output logic [NUM_READ*XLEN-1:0]           read_data_o,
  input  logic [NUM_WRITE-1:0]               write_enable_i,
  input  logic [NUM_WRITE*REG_ADDR_WIDTH-1:0] write_address_i,
  input  logic [NUM_WRITE*XLEN-1:0]          write_data_i
);
  localparam int            AW        = REG_ADDR_WIDTH;
  localparam int            DEPTH     = 1 << AW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [0:0]    INIT      = 1'b0;
  localparam logic [0:0]    RUN       = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [AW-1:0]        counter_q, counter_d;
  logic [XLEN-1:0]      mem_q [DEPTH];
  logic [XLEN-1:0]      mem_d [DEPTH];
  logic                 run;
  logic [NUM_WRITE-1:0] wr_valid;
  logic [AW-1:0]        raddr;
  logic [XLEN-1:0]      rdata;

  assign run     = (state_q == RUN);
  assign ready_o = run;

  // A write port counts only in RUN, outside reset, and not when it targets the hardwired zero register.
  always_comb begin
    wr_valid = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      wr_valid[w] = write_enable_i[w] && run && !rst_i &&
                    !((ZERO_REG != 0) && (write_address_i[w*AW +: AW] == '0));
    end
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    mem_d     = mem_q;
    if (!run) begin
      mem_d[counter_q] = '0;
      counter_d        = counter_q + 1'b1;
      if (counter_q == LAST_ADDR) begin
        state_d = RUN;
      end
    end else begin
      // Ascending port order lets the highest-index port win an address collision.
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wr_valid[w]) begin
          mem_d[write_address_i[w*AW +: AW]] = write_data_i[w*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= INIT;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
    mem_q <= mem_d;
  end

  always_comb begin
    read_data_o = '0;
    raddr       = '0;
    rdata       = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      raddr = read_address_i[p*AW +: AW];
      rdata = mem_q[raddr];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (wr_valid[w] && (write_address_i[w*AW +: AW] == raddr)) begin
            rdata = write_data_i[w*XLEN +: XLEN];
          end
        end
      end
      if (!run || ((ZERO_REG != 0) && (raddr == '0))) begin
        rdata = '0;
      end
      read_data_o[p*XLEN +: XLEN] = rdata;
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: a bypassing and a non-bypassing instance share stimulus and
// are compared every cycle against an array-based model, plus hand-computed literal checks.
module tb_regfile_multiport;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NR*AW-1:0]   readAddr = '0;
  logic [NR*XLEN-1:0] readData, readDataNb;
  logic               ready, readyNb;
  logic [NW-1:0]      writeEn = '0;
  logic [NW*AW-1:0]   writeAddr = '0;
  logic [NW*XLEN-1:0] writeData = '0;

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;

  // Model: the register contents, plus how many clear cycles remain before the file is usable
  logic [XLEN-1:0] modelMem [DEPTH];
  int              pending = 0;

  always #5 clk = ~clk;

  regfile_multiport #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW),
                      .BYPASS(1), .ZERO_REG(1)) dut (
    .clk_i(clk), .rst_i(rst), .ready_o(ready),
    .read_address_i(readAddr), .read_data_o(readData),
    .write_enable_i(writeEn), .write_address_i(writeAddr), .write_data_i(writeData)
  );

  regfile_multiport #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW),
                      .BYPASS(0), .ZERO_REG(1)) dutNb (
    .clk_i(clk), .rst_i(rst), .ready_o(readyNb),
    .read_address_i(readAddr), .read_data_o(readDataNb),
    .write_enable_i(writeEn), .write_address_i(writeAddr), .write_data_i(writeData)
  );

  // Reset arms a DEPTH-cycle clear; after it every register is 0; in RUN writes land in port order
  always @(posedge clk) begin
    if (rst) begin
      pending <= DEPTH;
    end else if (pending > 0) begin
      pending <= pending - 1;
      if (pending == 1) begin
        for (int i = 0; i < DEPTH; i++) modelMem[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (writeEn[w] && writeAddr[w*AW +: AW] != '0)
          modelMem[writeAddr[w*AW +: AW]] <= writeData[w*XLEN +: XLEN];
      end
    end
  end

  function automatic logic [XLEN-1:0] expRead(input logic [AW-1:0] a, input bit byp);
    logic [XLEN-1:0] v;
    if (pending > 0 || a == '0) return '0;
    v = modelMem[a];
    if (byp && !rst) begin
      for (int w = 0; w < NW; w++)
        if (writeEn[w] && writeAddr[w*AW +: AW] == a) v = writeData[w*XLEN +: XLEN];
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Mid-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("ready", {31'b0, ready}, {31'b0, pending == 0});
      checkOutput("readyNb", {31'b0, readyNb}, {31'b0, pending == 0});
      for (int p = 0; p < NR; p++) begin
        checkOutput("readBypass", readData[p*XLEN +: XLEN], expRead(readAddr[p*AW +: AW], 1'b1));
        checkOutput("readNoBypass", readDataNb[p*XLEN +: XLEN], expRead(readAddr[p*AW +: AW], 1'b0));
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic [NW-1:0] we,
                               input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                               input logic [XLEN-1:0] wd0, input logic [XLEN-1:0] wd1,
                               input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    rst       = r;
    writeEn   = we;
    writeAddr = {wa1, wa0};
    writeData = {wd1, wd0};
    readAddr  = {ra1, ra0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] wa0, wa1, ra0, ra1;

    // Two reset cycles, then 32 clear cycles with writes attempted that must be dropped
    applyStimulus(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    tick();
    checking = 1'b1;
    tick();
    for (int k = 1; k <= DEPTH; k++) begin
      applyStimulus(1'b0, 2'b11, 5'd9, 5'd10, 32'hFF, 32'hFF, 5'd9, AW'(k));
      tick();
      checkOutput("readyAfterClear", {31'b0, ready}, (k == DEPTH) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd10);
    #1 checkOutput("initWriteDropped9", readData[31:0], 32'h0);
    checkOutput("initWriteDropped10", readData[63:32], 32'h0);
    tick();

    // Simple write then read on the other port
    applyStimulus(1'b0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 5'd1, 5'd2);
    tick();
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd5);
    #1 checkOutput("writeThenRead", readData[63:32], 32'hDEADBEEF);
    tick();

    // Zero-register write dropped while the other port lands
    applyStimulus(1'b0, 2'b11, 5'd0, 5'd3, 32'h1234, 32'h55, 5'd4, 5'd6);
    tick();
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd3);
    #1 checkOutput("zeroReg", readData[31:0], 32'h0);
    checkOutput("otherPortLands", readData[63:32], 32'h55);
    tick();

    // Collision on address 7: port 1 wins, bypass visible only on the bypassing instance
    applyStimulus(1'b0, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 5'd7, 5'd7);
    #1 checkOutput("collisionBypass", readData[31:0], 32'h22);
    checkOutput("collisionNoBypassOld", readDataNb[31:0], 32'h0);
    tick();
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0);
    #1 checkOutput("collisionNoBypassNew", readDataNb[31:0], 32'h22);
    checkOutput("collisionStored", readData[31:0], 32'h22);
    tick();

    // Fill part of the file with index values, then reset mid-way
    for (int i = 1; i < 15; i += 2) begin
      applyStimulus(1'b0, 2'b11, AW'(i), AW'(i + 1), XLEN'(i), XLEN'(i + 1), 5'd0, 5'd0);
      tick();
    end
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd13);
    #1 checkOutput("fillReg4", readData[31:0], 32'd4);
    checkOutput("fillReg13", readData[63:32], 32'd13);
    tick();
    applyStimulus(1'b1, 2'b11, 5'd15, 5'd16, 32'd15, 32'd16, 5'd15, 5'd4);
    tick();
    checkOutput("readyDropsOnReset", {31'b0, ready}, 32'd0);
    for (int k = 1; k <= DEPTH; k++) begin
      applyStimulus(1'b0, 2'b11, AW'(k), AW'(k + 7), 32'hA5A5A5A5, 32'h5A5A5A5A, AW'(k), 5'd4);
      tick();
    end
    checkOutput("readyAfterMidReset", {31'b0, ready}, 32'd1);
    for (int i = 1; i < DEPTH; i++) begin
      applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, AW'(i), AW'(DEPTH - i));
      #1 checkOutput("clearedAfterReset", readData[31:0], 32'h0);
      tick();
    end

    // Randomized traffic with occasional resets; collisions forced via a narrow address window
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        wa0 = AW'($urandom_range(0, 3));
        wa1 = AW'($urandom_range(0, 3));
      end else begin
        wa0 = AW'($urandom);
        wa1 = AW'($urandom);
      end
      ra0 = ($urandom_range(0, 2) == 0) ? wa1 : AW'($urandom);
      ra1 = ($urandom_range(0, 2) == 0) ? wa0 : AW'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 149) == 0, NW'($urandom), wa0, wa1,
                    $urandom, $urandom, ra0, ra1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
